// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_pkg
//  Brief    : Shared types and helpers for the floating-point multiplier pipe.
//  Revision : 1.0
// ============================================================================
package mul_pkg;

    localparam int unsigned DEF_EXPO_W = 8;
    localparam int unsigned DEF_MANT_W = 23;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Narrow control half of the stage-R payload; wide fields sit beside it.
    typedef struct packed {
        logic       sign;
        logic [2:0] rm;
        logic       nan;
        logic       inf;
        logic       zero;
        logic       nv;
        logic       inexact;
        logic       tiny;
    } r_ctrl_t;

    // Overflow saturates to max-finite only when rounding toward zero's side.
    function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
        case (rm)
            RM_RTZ:  ovf_to_inf = 1'b0;
            RM_RDN:  ovf_to_inf = sign;
            RM_RUP:  ovf_to_inf = !sign;
            default: ovf_to_inf = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_round_pack_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_round_pack_if
//  Brief    : Upstream/downstream handshake bundle of the round/pack stage.
//  Revision : 1.0
// ============================================================================
interface mul_round_pack_if
    import mul_pkg::*;
#(
    parameter int unsigned EXPO_W = DEF_EXPO_W,
    parameter int unsigned MANT_W = DEF_MANT_W
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_sign;
    logic [2:0]                 in_rm;
    logic [EXPO_W+1:0]          in_expo;
    logic [2*MANT_W+1:0]        in_mant;
    logic                       in_underflow;
    logic                       in_inexact_sft;
    logic                       in_bit_s;
    logic                       in_nan;
    logic                       in_inf;
    logic                       in_zero;
    logic                       in_nv;
    logic                       out_valid;
    logic                       out_ready;
    logic [EXPO_W+MANT_W:0]     out_result;
    logic [4:0]                 out_fflags;

    modport master (
        output flush, in_valid, in_sign, in_rm, in_expo, in_mant,
               in_underflow, in_inexact_sft, in_bit_s,
               in_nan, in_inf, in_zero, in_nv, out_ready,
        input  in_ready, out_valid, out_result, out_fflags
    );

    modport slave (
        input  flush, in_valid, in_sign, in_rm, in_expo, in_mant,
               in_underflow, in_inexact_sft, in_bit_s,
               in_nan, in_inf, in_zero, in_nv, out_ready,
        output in_ready, out_valid, out_result, out_fflags
    );

endinterface
`default_nettype wire

// File: rtl/mul_round_inc.sv
`default_nettype none
// ============================================================================
//  Module   : mul_round_inc
//  Brief    : IEEE-754 round-increment decision from rm, sign, lsb, guard, sticky.
//  Revision : 1.0
// ============================================================================
module mul_round_inc
    import mul_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       s,
    output logic       inc,
    output logic       inexact
);

    always_comb begin
        inexact = g | s;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (g | s);
            RM_RUP:  inc = !sign & (g | s);
            RM_RMM:  inc = g;
            default: inc = g & (s | lsb);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mul_round_pack.sv
`default_nettype none
// ============================================================================
//  Module   : mul_round_pack
//  Brief    : FP multiplier final stage: round, overflow detect, pack + flags.
//  Revision : 1.0
// ============================================================================
module mul_round_pack
    import mul_pkg::*;
#(
    parameter int unsigned EXPO_W = DEF_EXPO_W,
    parameter int unsigned MANT_W = DEF_MANT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    mul_round_pack_if.slave   bus
);

    localparam int unsigned RES_W = 1 + EXPO_W + MANT_W;
    localparam int unsigned SUM_W = MANT_W + 2;
    localparam int unsigned EF_W  = EXPO_W + 3;

    localparam logic [EF_W-1:0]          C_EXPO_OVF = {3'b000, {EXPO_W{1'b1}}};
    localparam logic [RES_W-1:0]         C_NAN      = {1'b0, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [RES_W-2:0]         C_INF_MAG  = {{EXPO_W{1'b1}}, {MANT_W{1'b0}}};
    localparam logic [RES_W-2:0]         C_MAXF_MAG = {{(EXPO_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};

    logic                r_valid;
    logic                p_valid;
    logic                p_load;
    logic                accept;

    r_ctrl_t             r_ctrl;
    logic [EXPO_W+1:0]   r_expo;
    logic [SUM_W-1:0]    r_sum;

    logic [RES_W-1:0]    p_result;
    fflags_t             p_flags;

    // Handshake
    assign p_load       = !p_valid | bus.out_ready;
    assign bus.in_ready = !r_valid | p_load;
    assign accept       = bus.in_valid & bus.in_ready & !bus.flush;

    // Stage R: rounding decision on the incoming mantissa
    logic [MANT_W-1:0]   w_frac;
    logic                w_hid;
    logic                w_g;
    logic                w_s;
    logic                w_inc;
    logic                w_inexact;
    logic                unused_mant_msb;

    assign w_frac          = bus.in_mant[2*MANT_W-1:MANT_W];
    assign w_hid           = bus.in_mant[2*MANT_W];
    assign w_g             = bus.in_mant[MANT_W-1];
    assign w_s             = (|bus.in_mant[MANT_W-2:0]) | bus.in_bit_s | bus.in_inexact_sft;
    assign unused_mant_msb = bus.in_mant[2*MANT_W+1];

    mul_round_inc u_round_inc (
        .rm      (bus.in_rm),
        .sign    (bus.in_sign),
        .lsb     (w_frac[0]),
        .g       (w_g),
        .s       (w_s),
        .inc     (w_inc),
        .inexact (w_inexact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (bus.in_ready) begin
            r_valid <= bus.in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '0;
            r_expo <= '0;
            r_sum  <= '0;
        end else if (accept) begin
            r_ctrl <= '{sign:    bus.in_sign,
                        rm:      bus.in_rm,
                        nan:     bus.in_nan,
                        inf:     bus.in_inf,
                        zero:    bus.in_zero,
                        nv:      bus.in_nv,
                        inexact: w_inexact,
                        tiny:    bus.in_underflow};
            r_expo <= bus.in_expo;
            r_sum  <= {1'b0, w_hid, w_frac} + {{(SUM_W-1){1'b0}}, w_inc};
        end
    end

    // Stage P: exponent adjust, overflow saturation, special override
    logic                w_carry;
    logic [EF_W-1:0]     w_expo;
    logic [MANT_W-1:0]   w_pfrac;
    logic                w_of;
    logic [RES_W-1:0]    w_result;
    fflags_t             w_flags;

    always_comb begin
        w_carry = r_sum[MANT_W+1];
        w_pfrac = w_carry ? '0 : r_sum[MANT_W-1:0];
        // A subnormal that rounded its hidden bit in is now the minimum normal.
        if ((r_expo == '0) && r_sum[MANT_W]) begin
            w_expo = {{(EF_W-1){1'b0}}, 1'b1};
        end else begin
            w_expo = {1'b0, r_expo} + {{(EF_W-1){1'b0}}, w_carry};
        end
        w_of     = (w_expo >= C_EXPO_OVF);
        w_flags  = '0;
        w_result = {r_ctrl.sign, w_expo[EXPO_W-1:0], w_pfrac};

        if (r_ctrl.nan) begin
            w_result   = C_NAN;
            w_flags.nv = r_ctrl.nv;
        end else if (r_ctrl.inf) begin
            w_result = {r_ctrl.sign, C_INF_MAG};
        end else if (r_ctrl.zero) begin
            w_result = {r_ctrl.sign, {(RES_W-1){1'b0}}};
        end else begin
            w_flags.uf = r_ctrl.tiny & r_ctrl.inexact;
            w_flags.nx = r_ctrl.inexact;
            if (w_of) begin
                w_flags.of = 1'b1;
                w_flags.nx = 1'b1;
                w_result   = ovf_to_inf(r_ctrl.rm, r_ctrl.sign) ?
                             {r_ctrl.sign, C_INF_MAG} : {r_ctrl.sign, C_MAXF_MAG};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
        end else if (bus.flush) begin
            p_valid <= 1'b0;
        end else if (p_load) begin
            p_valid <= r_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_result <= '0;
            p_flags  <= '0;
        end else if (p_load && r_valid && !bus.flush) begin
            p_result <= w_result;
            p_flags  <= w_flags;
        end
    end

    assign bus.out_valid  = p_valid;
    assign bus.out_result = p_result;
    assign bus.out_fflags = p_flags;

endmodule
`default_nettype wire

// File: tb/tb_mul_round_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_round_pack
//  Brief    : Scoreboard bench for mul_round_pack with directed vectors.
//  Revision : 1.0
// ============================================================================
module tb_mul_round_pack;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flags;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    mul_round_pack_if #(.EXPO_W(8), .MANT_W(23)) bus ();

    mul_round_pack #(.EXPO_W(8), .MANT_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ctl = {underflow, inexact_sft, bit_s, nan, inf, zero, nv}
    task automatic send(input logic sgn, input logic [2:0] rm, input logic [9:0] ex,
                        input logic [47:0] m, input logic [6:0] ctl,
                        input logic [31:0] er, input logic [4:0] ef);
        bit done;
        done               = 1'b0;
        bus.in_valid       = 1'b1;
        bus.in_sign        = sgn;
        bus.in_rm          = rm;
        bus.in_expo        = ex;
        bus.in_mant        = m;
        bus.in_underflow   = ctl[6];
        bus.in_inexact_sft = ctl[5];
        bus.in_bit_s       = ctl[4];
        bus.in_nan         = ctl[3];
        bus.in_inf         = ctl[2];
        bus.in_zero        = ctl[1];
        bus.in_nv          = ctl[0];
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back('{res: er, flags: ef});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: pops on every transfer, checks hold stability while stalled
    initial begin
        exp_t        e;
        bit          hold;
        logic [31:0] h_res;
        logic [4:0]  h_flg;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || bus.flush) begin
                hold = 1'b0;
            end else if (bus.out_valid) begin
                if (hold) begin
                    chk("stall_result", bus.out_result, h_res);
                    chk("stall_flags", {27'd0, bus.out_fflags}, {27'd0, h_flg});
                end
                if (bus.out_ready) begin
                    hold = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got %h expected none", bus.out_result);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", bus.out_result, e.res);
                        chk("fflags", {27'd0, bus.out_fflags}, {27'd0, e.flags});
                    end
                end else begin
                    hold  = 1'b1;
                    h_res = bus.out_result;
                    h_flg = bus.out_fflags;
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    localparam logic [47:0] M_ONE  = 48'h4000_0000_0000;
    localparam logic [47:0] M_TIE0 = 48'h4000_0040_0000;
    localparam logic [47:0] M_TIE1 = 48'h4000_00C0_0000;
    localparam logic [47:0] M_STK  = 48'h4000_0000_0001;
    localparam logic [47:0] M_CRY  = 48'h7FFF_FFC0_0000;
    localparam logic [47:0] M_SUBR = 48'h3FFF_FFC0_0000;
    localparam logic [47:0] M_SUBX = 48'h2000_0000_0000;

    initial begin
        checks             = 0;
        errors             = 0;
        rst_n              = 1'b0;
        bus.flush          = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_sign        = 1'b0;
        bus.in_rm          = 3'd0;
        bus.in_expo        = '0;
        bus.in_mant        = '0;
        bus.in_underflow   = 1'b0;
        bus.in_inexact_sft = 1'b0;
        bus.in_bit_s       = 1'b0;
        bus.in_nan         = 1'b0;
        bus.in_inf         = 1'b0;
        bus.in_zero        = 1'b0;
        bus.in_nv          = 1'b0;
        bus.out_ready      = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_result", bus.out_result, 0);
        chk("rst_fflags", {27'd0, bus.out_fflags}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);

        // Latency: accepted at edge E0, out_valid visible after edge E1
        send(1'b0, 3'd0, 10'd127, M_ONE, 7'b0, 32'h3F80_0000, 5'b00000);
        chk("lat_e0_valid", {31'd0, bus.out_valid}, 0);
        @(posedge clk);
        #1;
        chk("lat_e1_valid", {31'd0, bus.out_valid}, 1);

        // Directed rounding / overflow / subnormal / specials, back-to-back
        send(1'b0, 3'd0, 10'd127, M_TIE0, 7'b0000000, 32'h3F80_0000, 5'b00001);
        send(1'b0, 3'd0, 10'd127, M_TIE1, 7'b0000000, 32'h3F80_0002, 5'b00001);
        send(1'b0, 3'd0, 10'd255, M_ONE,  7'b0000000, 32'h7F80_0000, 5'b00101);
        send(1'b0, 3'd1, 10'd255, M_ONE,  7'b0000000, 32'h7F7F_FFFF, 5'b00101);
        send(1'b1, 3'd2, 10'd255, M_ONE,  7'b0000000, 32'hFF80_0000, 5'b00101);
        send(1'b1, 3'd3, 10'd255, M_ONE,  7'b0000000, 32'hFF7F_FFFF, 5'b00101);
        send(1'b0, 3'd0, 10'd0,   M_SUBR, 7'b1000000, 32'h0080_0000, 5'b00011);
        send(1'b0, 3'd0, 10'd0,   M_SUBX, 7'b1000000, 32'h0040_0000, 5'b00000);
        send(1'b0, 3'd3, 10'd127, M_STK,  7'b0000000, 32'h3F80_0001, 5'b00001);
        send(1'b1, 3'd2, 10'd127, M_STK,  7'b0000000, 32'hBF80_0001, 5'b00001);
        send(1'b0, 3'd4, 10'd127, M_TIE0, 7'b0000000, 32'h3F80_0001, 5'b00001);
        send(1'b0, 3'd1, 10'd127, M_TIE0, 7'b0000000, 32'h3F80_0000, 5'b00001);
        send(1'b0, 3'd0, 10'd127, M_TIE0, 7'b0010000, 32'h3F80_0001, 5'b00001);
        send(1'b0, 3'd0, 10'd127, M_ONE,  7'b0100000, 32'h3F80_0000, 5'b00001);
        send(1'b0, 3'd0, 10'd127, M_CRY,  7'b0000000, 32'h4000_0000, 5'b00001);
        send(1'b0, 3'd5, 10'd127, M_TIE1, 7'b0000000, 32'h3F80_0002, 5'b00001);
        send(1'b0, 3'd0, 10'd0,   48'd0,  7'b0001001, 32'h7FC0_0000, 5'b10000);
        send(1'b1, 3'd0, 10'd0,   48'd0,  7'b0000100, 32'hFF80_0000, 5'b00000);
        send(1'b1, 3'd0, 10'd0,   48'd0,  7'b0000010, 32'h8000_0000, 5'b00000);
        send(1'b0, 3'd0, 10'd0,   48'd0,  7'b0001100, 32'h7FC0_0000, 5'b00000);
        drain();

        // Back-pressure: 4 ops while the consumer stalls for 6 cycles
        bus.out_ready = 1'b0;
        fork
            begin
                send(1'b0, 3'd0, 10'd127, M_ONE, 7'b0, 32'h3F80_0000, 5'b0);
                send(1'b0, 3'd0, 10'd128, M_ONE, 7'b0, 32'h4000_0000, 5'b0);
                send(1'b0, 3'd0, 10'd129, M_ONE, 7'b0, 32'h4080_0000, 5'b0);
                send(1'b0, 3'd0, 10'd130, M_ONE, 7'b0, 32'h4100_0000, 5'b0);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #2;
                chk("bp_in_ready_low", {31'd0, bus.in_ready}, 0);
                chk("bp_out_valid", {31'd0, bus.out_valid}, 1);
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Flush with two in flight, plus a same-cycle request that must be ignored
        bus.out_ready = 1'b0;
        send(1'b0, 3'd0, 10'd127, M_ONE, 7'b0, 32'h3F80_0000, 5'b0);
        send(1'b0, 3'd0, 10'd128, M_ONE, 7'b0, 32'h4000_0000, 5'b0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", {31'd0, bus.out_valid}, 0);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 1);
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_quiet", {31'd0, bus.out_valid}, 0);

        // Asynchronous reset mid-stream
        send(1'b0, 3'd0, 10'd127, M_ONE, 7'b0, 32'h3F80_0000, 5'b0);
        send(1'b0, 3'd0, 10'd128, M_ONE, 7'b0, 32'h4000_0000, 5'b0);
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bus.out_valid}, 0);
        chk("async_rst_result", bus.out_result, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 1);
        send(1'b0, 3'd0, 10'd0, 48'd0, 7'b0001001, 32'h7FC0_0000, 5'b10000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
